// File: rtl/hermes_local_injector.sv
// hermes_local_injector: host-side payload FIFO plus packet sequencer feeding
// a Hermes router LOCAL input port (header flit, size flit, payload flits).
// Optional build macro: HERMES_INJ_CHECKSUM_EN appends an XOR checksum flit
// and makes the size flit count it. The port list is identical in both builds.
module hermes_local_injector #(
    parameter int unsigned FLIT_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned LEN_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [FLIT_W-1:0] wr_data,
    output logic              fifo_full,
    output logic [LEN_W-1:0]  fifo_count,
    input  logic              send,
    input  logic [15:0]       target_xy,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              tx,
    output logic [FLIT_W-1:0] data_out,
    input  logic              credit_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StSize,
        StPayload,
`ifdef HERMES_INJ_CHECKSUM_EN
        StCsum,
`endif
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [FLIT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LEN_W-1:0]   count_q, count_d;
    logic               full_q;
    logic [15:0]        tgt_q, tgt_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [FLIT_W-1:0]  last_q;
    logic [FLIT_W-1:0]  flit;
    logic               err_q, err_d;
    logic               push, pop;
`ifdef HERMES_INJ_CHECKSUM_EN
    logic [FLIT_W-1:0]  csum_q, csum_d;
`endif

    // full is the registered flag, so a push while full is dropped even if a pop coincides
    assign push       = wr_en && !full_q;
    assign pop        = (state_q == StPayload) && credit_i;
    assign fifo_full  = full_q;
    assign fifo_count = count_q;
    assign err        = err_q;
    assign data_out   = flit;

    // Payload storage; contents are discarded on reset by clearing the pointers
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Occupancy next-state: simultaneous push and pop leave the count unchanged
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + LEN_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - LEN_W'(1);
        end
    end

    // FIFO pointers, count and full flag; pointers wrap naturally at DEPTH
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == LEN_W'(DEPTH));
        end
    end

    // Packet sequencer: next state, latched request fields and flit outputs
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        rem_d   = rem_q;
        err_d   = 1'b0;
        tx      = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        flit    = last_q;
`ifdef HERMES_INJ_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (send) begin
                    if ((length != '0) && (length <= count_q)) begin
                        state_d = StHeader;
                        tgt_d   = target_xy;
                        rem_d   = length;
`ifdef HERMES_INJ_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StHeader: begin
                tx   = 1'b1;
                busy = 1'b1;
                flit = FLIT_W'(tgt_q);
                if (credit_i) begin
                    state_d = StSize;
                end
            end
            StSize: begin
                tx   = 1'b1;
                busy = 1'b1;
`ifdef HERMES_INJ_CHECKSUM_EN
                flit = FLIT_W'(rem_q) + FLIT_W'(1);
`else
                flit = FLIT_W'(rem_q);
`endif
                if (credit_i) begin
                    state_d = StPayload;
                end
            end
            StPayload: begin
                tx   = 1'b1;
                busy = 1'b1;
                flit = mem[rd_ptr_q];
                if (credit_i) begin
                    rem_d = rem_q - LEN_W'(1);
`ifdef HERMES_INJ_CHECKSUM_EN
                    csum_d = csum_q ^ mem[rd_ptr_q];
                    if (rem_q == LEN_W'(1)) begin
                        state_d = StCsum;
                    end
`else
                    if (rem_q == LEN_W'(1)) begin
                        state_d = StDone;
                    end
`endif
                end
            end
`ifdef HERMES_INJ_CHECKSUM_EN
            StCsum: begin
                tx   = 1'b1;
                busy = 1'b1;
                flit = csum_q;
                if (credit_i) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer state; last_q keeps data_out stable while tx is low
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            tgt_q   <= '0;
            rem_q   <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            rem_q   <= rem_d;
            last_q  <= flit;
            err_q   <= err_d;
        end
    end

`ifdef HERMES_INJ_CHECKSUM_EN
    // Running XOR of the payload words of the packet in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

endmodule

// File: tb/tb_hermes_local_injector.sv
// Directed bench for hermes_local_injector with a flit scoreboard.
module tb_hermes_local_injector;

    localparam int unsigned FLIT_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LEN_W  = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic [FLIT_W-1:0] wr_data = '0;
    logic              fifo_full;
    logic [LEN_W-1:0]  fifo_count;
    logic              send = 1'b0;
    logic [15:0]       target_xy = '0;
    logic [LEN_W-1:0]  length = '0;
    logic              busy, done, err, tx;
    logic [FLIT_W-1:0] data_out;
    logic              credit_i = 1'b1;

    int checks = 0;
    int fails  = 0;
    int acc_cnt = 0;
    int cyc;
    logic [31:0] sb[$];
    logic [31:0] model[$];

    hermes_local_injector #(
        .FLIT_W(FLIT_W),
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .fifo_full (fifo_full),
        .fifo_count(fifo_count),
        .send      (send),
        .target_xy (target_xy),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tx        (tx),
        .data_out  (data_out),
        .credit_i  (credit_i)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every accepted flit is compared against the scoreboard head
    always @(negedge clock) begin
        if (reset && tx && credit_i) begin
            acc_cnt++;
            if (sb.size() == 0) chk("flit_unexpected", 32'(sb.size()), 32'd1);
            else chk("flit", data_out, sb.pop_front());
        end
    end

    // All tasks start and end just after a rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        wr_en = 1'b1;
        wr_data = w;
        model.push_back(w);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push_drop(input logic [31:0] w);
        wr_en = 1'b1;
        wr_data = w;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] t, input int len);
        logic [31:0] cs = '0;
        logic [31:0] w;
        sb.push_back({16'h0, t});
`ifdef HERMES_INJ_CHECKSUM_EN
        sb.push_back(32'(len + 1));
`else
        sb.push_back(32'(len));
`endif
        for (int i = 0; i < len; i++) begin
            w = model.pop_front();
            cs = cs ^ w;
            sb.push_back(w);
        end
`ifdef HERMES_INJ_CHECKSUM_EN
        sb.push_back(cs);
`endif
        acc_cnt = 0;
        send = 1'b1;
        target_xy = t;
        length = LEN_W'(len);
        tick();
        send = 1'b0;
    endtask

    task automatic send_bad(input int len);
        send = 1'b1;
        target_xy = 16'hFFFF;
        length = LEN_W'(len);
        tick();
        send = 1'b0;
        @(negedge clock);
        chk("err_pulse", err, 1'b1);
        chk("err_busy", busy, 1'b0);
        chk("err_tx", tx, 1'b0);
        @(negedge clock);
        chk("err_once", err, 1'b0);
        chk("err_tx2", tx, 1'b0);
        tick();
    endtask

    // Counts falling edges until done; ends on the falling edge of the done cycle
    task automatic wait_done(output int c);
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (done !== 1'b1 && c < 300);
        chk("done_seen", done, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_tx", tx, 1'b0);
    endtask

    task automatic finish_pkt(input int flits);
        chk("pkt_flits", 32'(acc_cnt), 32'(flits));
        tick();
        @(negedge clock);
        chk("done_once", done, 1'b0);
        tick();
    endtask

`ifdef HERMES_INJ_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    initial begin
        // Reset state
        tick();
        chk("rst_tx", tx, 1'b0);
        chk("rst_data", data_out, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_full", fifo_full, 1'b0);
        reset = 1'b1;
        tick();

        // Single-word packet with credit held high
        push(32'h0000_0002);
        send_pkt(16'h0102, 1);
        wait_done(cyc);
        chk("p1_latency", 32'(cyc), 32'(4 + EXTRA));
        chk("p1_count", 32'(fifo_count), 32'd0);
        finish_pkt(3 + EXTRA);

        // Four words with a three-cycle stall on the second payload flit
        for (int i = 0; i < 4; i++) push(32'hA000_0000 + 32'(i));
        send_pkt(16'h0305, 4);
        tick();
        tick();
        tick();
        credit_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_tx", tx, 1'b1);
            chk("stall_data", data_out, 32'hA000_0001);
            chk("stall_count", 32'(fifo_count), 32'd3);
            tick();
        end
        credit_i = 1'b1;
        wait_done(cyc);
        finish_pkt(6 + EXTRA);

        // Rejected sends
        send_bad(0);
        for (int i = 0; i < 3; i++) push(32'hB000_0000 + 32'(i));
        send_bad(5);
        @(negedge clock);
        chk("bad_count", 32'(fifo_count), 32'd3);
        tick();

        // Fill to DEPTH, drop the 17th push, send across pointer wrap
        for (int i = 0; i < 13; i++) push(32'hC000_0000 + 32'(i));
        @(negedge clock);
        chk("fill_full", fifo_full, 1'b1);
        chk("fill_count", 32'(fifo_count), 32'd16);
        tick();
        push_drop(32'hBAD0_BAD0);
        @(negedge clock);
        chk("drop_count", 32'(fifo_count), 32'd16);
        chk("drop_full", fifo_full, 1'b1);
        tick();
        send_pkt(16'h0A0B, 16);
        wait_done(cyc);
        chk("wrap_latency", 32'(cyc), 32'(19 + EXTRA));
        chk("wrap_count", 32'(fifo_count), 32'd0);
        chk("wrap_full", fifo_full, 1'b0);
        finish_pkt(18 + EXTRA);

        // Reset mid-payload after two of five words
        for (int i = 0; i < 5; i++) push(32'hD000_0000 + 32'(i));
        send_pkt(16'h0203, 5);
        tick();
        tick();
        tick();
        tick();
        chk("mid_pending", 32'(sb.size()), 32'(3 + EXTRA));
        reset = 1'b0;
        #1;
        chk("arst_tx", tx, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        sb.delete();
        model.delete();
        tick();
        reset = 1'b1;
        tick();
        push(32'h0000_0055);
        send_pkt(16'h0001, 1);
        wait_done(cyc);
        chk("post_latency", 32'(cyc), 32'(4 + EXTRA));
        finish_pkt(3 + EXTRA);

`ifdef HERMES_INJ_CHECKSUM_EN
        // Checksum flit
        push(32'h0F0F_0000);
        push(32'h00F0_F0F0);
        send_pkt(16'h0101, 2);
        wait_done(cyc);
        finish_pkt(5);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
